// File: rtl/fir_filter_ctrl.sv
// fir_filter_ctrl -- single-MAC, time-multiplexed FIR filter controller.
//
// Samples are accepted over a valid/ready handshake (i_ce / o_ready) and
// written into a circular delay line. The block then spends NTAPS cycles
// accumulating tap[k] * delay[newest-k] and one more cycle rounding,
// shifting and saturating into o_result. The tap bank is writable at run
// time, but only while the block is idle.
//
// Optional feature: define FIR_DC_REMOVE_EN to subtract a running DC
// estimate from each sample before it enters the delay line.
//
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_ce, o_ready    sample valid / block can accept a sample
//   i_sample         signed input sample (IW)
//   i_tap_wr/addr/tap  tap bank write port (honoured in IDLE only)
//   o_valid          one-cycle result strobe
//   o_result         signed filtered output (OW), held between strobes
//   o_busy           MAC in progress
//   i_ovf_clr, o_ovf sticky saturation flag and its clear
module fir_filter_ctrl #(
  parameter int IW       = 16,
  parameter int CW       = 16,
  parameter int OW       = 16,
  parameter int NTAPS    = 16,
  parameter int SHIFT    = 15,
  parameter int DC_SHIFT = 6
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_ce,
  output logic                       o_ready,
  input  logic signed [IW-1:0]       i_sample,
  input  logic                       i_tap_wr,
  input  logic [$clog2(NTAPS)-1:0]   i_tap_addr,
  input  logic signed [CW-1:0]       i_tap,
  output logic                       o_valid,
  output logic signed [OW-1:0]       o_result,
  output logic                       o_busy,
  input  logic                       i_ovf_clr,
  output logic                       o_ovf
);

  localparam int AddrW = $clog2(NTAPS);
  localparam int AW    = IW + CW + $clog2(NTAPS);
  // Rounding/shift/compare width: one guard bit over the accumulator and
  // wide enough to hold the output limits.
  localparam int RW    = (AW + 1 > OW + 1) ? AW + 1 : OW + 1;

  localparam logic [AddrW-1:0]      LAST    = AddrW'(NTAPS - 1);
  localparam logic [AddrW-1:0]      NT_MOD  = AddrW'(NTAPS);
  localparam logic signed [CW-1:0]  TAP_ONE = {1'b0, {(CW-1){1'b1}}};
  localparam logic signed [RW-1:0]  RND     = RW'(64'sd1 <<< (SHIFT - 1));
  localparam logic signed [RW-1:0]  OMAX    = RW'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [RW-1:0]  OMIN    = RW'(-(64'sd1 <<< (OW - 1)));

  if (NTAPS < 2 || SHIFT < 1 || DC_SHIFT < 1) begin : g_bad_param
    $error("fir_filter_ctrl: NTAPS>=2, SHIFT>=1, DC_SHIFT>=1 required");
  end

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

  state_e                  state_q, state_d;
  logic [AddrW-1:0]        wptr_q, wptr_d;
  logic [AddrW-1:0]        newest_q, newest_d;
  logic [AddrW-1:0]        k_q, k_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic                    valid_q, valid_d;
  logic signed [OW-1:0]    result_q, result_d;
  logic                    ovf_q, ovf_d;

  logic signed [CW-1:0]    tap_q   [NTAPS];
  logic signed [IW-1:0]    delay_q [NTAPS];

  logic                    accept, tap_we;
  logic signed [IW-1:0]    d_in;
  logic [AddrW-1:0]        idx;
  logic signed [IW+CW-1:0] prod;
  logic signed [RW-1:0]    rnd, shr;
  logic                    sat_hi, sat_lo;
  logic signed [OW-1:0]    sat_val;

  assign accept = (state_q == IDLE) && i_ce;
  assign tap_we = (state_q == IDLE) && i_tap_wr;

  // Delay-line tap index (newest - k) mod NTAPS. The raw difference is taken
  // mod 2^AddrW; adding NTAPS on borrow corrects it for non-power-of-2 depths.
  assign idx  = newest_q - k_q + ((newest_q < k_q) ? NT_MOD : '0);
  assign prod = tap_q[k_q] * delay_q[idx];

  // Round half up, arithmetic shift, clamp to OW.
  always_comb begin
    rnd    = RW'(acc_q) + RND;
    shr    = rnd >>> SHIFT;
    sat_hi = shr > OMAX;
    sat_lo = shr < OMIN;
    if (sat_hi)      sat_val = OW'(OMAX);
    else if (sat_lo) sat_val = OW'(OMIN);
    else             sat_val = shr[OW-1:0];
  end

`ifdef FIR_DC_REMOVE_EN
  // DC tracker: avg_q holds the running mean with DC_SHIFT fraction bits.
  // Adding the integer difference to the fixed-point register is the same
  // as adding (x - avg) >>> DC_SHIFT in integer units.
  localparam int DW = IW + DC_SHIFT;
  logic signed [DW-1:0] avg_q, avg_d;
  logic signed [IW-1:0] avg_int;
  logic signed [IW:0]   diff;

  always_comb begin
    avg_int = avg_q[DW-1:DC_SHIFT];
    diff    = (IW+1)'(i_sample) - (IW+1)'(avg_int);
    if (diff[IW] != diff[IW-1])
      d_in = diff[IW] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
    else
      d_in = diff[IW-1:0];
    avg_d = avg_q + DW'(diff);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)     avg_q <= '0;
    else if (accept) avg_q <= avg_d;
  end
`else
  assign d_in = i_sample;
`endif

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    newest_d = newest_q;
    k_d      = k_q;
    acc_d    = acc_q;
    valid_d  = 1'b0;
    result_d = result_q;
    ovf_d    = i_ovf_clr ? 1'b0 : ovf_q;
    unique case (state_q)
      IDLE: begin
        if (i_ce) begin
          newest_d = wptr_q;
          wptr_d   = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
          acc_d    = '0;
          k_d      = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + AW'(prod);
        k_d   = k_q + 1'b1;
        if (k_q == LAST) state_d = OUT;
      end
      OUT: begin
        valid_d  = 1'b1;
        result_d = sat_val;
        // A saturation outranks a simultaneous clear.
        if (sat_hi || sat_lo) ovf_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      newest_q <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      newest_q <= newest_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // Tap bank and delay line. A tap write and a sample accept on the same
  // edge both land here, so the MAC that follows sees the new tap.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        tap_q[i]   <= (i == 0) ? TAP_ONE : '0;
        delay_q[i] <= '0;
      end
    end else begin
      if (tap_we) tap_q[i_tap_addr] <= i_tap;
      if (accept) delay_q[wptr_q]   <= d_in;
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_busy   = (state_q == MAC);
  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_ovf    = ovf_q;

endmodule

// File: tb/tb_fir_filter_ctrl.sv
module tb_fir_filter_ctrl;
  localparam int NT  = 4;
  localparam int DCS = 2;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_ce = 1'b0;
  logic              o_ready;
  logic signed [15:0] i_sample = '0;
  logic              i_tap_wr = 1'b0;
  logic [1:0]        i_tap_addr = '0;
  logic signed [15:0] i_tap = '0;
  logic              o_valid;
  logic signed [15:0] o_result;
  logic              o_busy;
  logic              i_ovf_clr = 1'b0;
  logic              o_ovf;

  fir_filter_ctrl #(.IW(16), .CW(16), .OW(16), .NTAPS(NT), .SHIFT(15), .DC_SHIFT(DCS)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .o_ready(o_ready),
    .i_sample(i_sample), .i_tap_wr(i_tap_wr), .i_tap_addr(i_tap_addr),
    .i_tap(i_tap), .o_valid(o_valid), .o_result(o_result), .o_busy(o_busy),
    .i_ovf_clr(i_ovf_clr), .o_ovf(o_ovf)
  );

  always #5 i_clk = ~i_clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: newest-first sample history and tap values.
  longint taps_m [NT];
  longint hist_m [NT];
  longint avg_m;
  bit     ovf_m;

  typedef struct {
    bit rst;
    bit wr;
    int tap;
    int sample;
    int exp;
    bit ovf;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic longint clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic m_reset();
    taps_m = '{32767, 0, 0, 0};
    hist_m = '{default: 0};
    avg_m  = 0;
    ovf_m  = 0;
  endtask

  task automatic m_accept(input longint x, output longint exp);
    longint d, sum, r;
`ifdef FIR_DC_REMOVE_EN
    d = clamp16(x - (avg_m >>> DCS));
    avg_m = avg_m + (x - (avg_m >>> DCS));
`else
    d = x;
`endif
    for (int k = NT - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
    hist_m[0] = d;
    sum = 0;
    for (int k = 0; k < NT; k++) sum += taps_m[k] * hist_m[k];
    r = (sum + 16384) >>> 15;
    exp = clamp16(r);
    if (exp != r) ovf_m = 1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    m_reset();
  endtask

  task automatic wr_tap(input int a, input longint v);
    longint vv;
    vv = v;
    i_tap_addr = a[1:0];
    i_tap = vv[15:0];
    i_tap_wr = 1'b1;
    tick();
    i_tap_wr = 1'b0;
    taps_m[a] = v;
  endtask

  task automatic send(input longint x, input string nm, output longint got);
    int w;
    longint exp, xx;
    xx = x;
    w = 0;
    while (!o_ready && w < 20) begin tick(); w++; end
    chk({nm, "_ready"}, longint'(o_ready), 1);
    i_sample = xx[15:0];
    i_ce = 1'b1;
    tick();
    i_ce = 1'b0;
    m_accept(x, exp);
    w = 0;
    do begin tick(); w++; end while (!o_valid && w < 20);
    chk({nm, "_latency"}, w, NT + 1);
    chk({nm, "_result"}, o_result, exp);
    chk({nm, "_ovf"}, longint'(o_ovf), longint'(ovf_m));
    got = o_result;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    longint got, e, prev, r;
    longint q[$];
    int last, lowrun, acc_n;
    bit seen;

    tbl[0] = '{1, 0, 0,       1000,   1000,   0};
    tbl[1] = '{1, 1, 'h2000,  4000,   1000,   0};
    tbl[2] = '{0, 0, 0,       4000,   2000,   0};
    tbl[3] = '{0, 0, 0,       4000,   3000,   0};
    tbl[4] = '{0, 0, 0,       4000,   4000,   0};
    tbl[5] = '{0, 1, 'h7FFF,  32767,  32767,  1};
    tbl[6] = '{1, 1, 'h7FFF, -32768, -32767,  0};
    tbl[7] = '{0, 0, 0,      -32768, -32768,  1};
    tbl[8] = '{0, 0, 0,      -32768, -32768,  1};
    tbl[9] = '{0, 0, 0,      -32768, -32768,  1};

    // Reset state
    do_reset();
    chk("rst_ready", longint'(o_ready), 1);
    chk("rst_valid", longint'(o_valid), 0);
    chk("rst_result", o_result, 0);
    chk("rst_busy", longint'(o_busy), 0);
    chk("rst_ovf", longint'(o_ovf), 0);

`ifndef FIR_DC_REMOVE_EN
    // Table-driven vectors: passthrough, equal-tap averaging, saturation
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      if (tbl[i].wr) for (int a = 0; a < NT; a++) wr_tap(a, tbl[i].tap);
      send(tbl[i].sample, $sformatf("tbl%0d", i), got);
      chk($sformatf("tbl%0d_const", i), got, tbl[i].exp);
      chk($sformatf("tbl%0d_ovfconst", i), longint'(o_ovf), longint'(tbl[i].ovf));
    end

    // Clear sticky overflow
    i_ovf_clr = 1'b1;
    tick();
    i_ovf_clr = 1'b0;
    ovf_m = 0;
    chk("ovf_clr", longint'(o_ovf), 0);

    // Saturation and clear on the same edge: the set wins
    i_ovf_clr = 1'b1;
    send(-32768, "ovf_setwins", got);
    i_ovf_clr = 1'b0;
    ovf_m = 0;
`else
    // DC removal: constant input decays toward zero
    prev = 32767;
    for (int i = 0; i < 40; i++) begin
      send(800, $sformatf("dc%0d", i), got);
      chk("dc_monotonic", longint'(got <= prev), 1);
      prev = got;
    end
    chk("dc_final_small", longint'(prev <= 4 && prev >= -4), 1);
`endif

    // Tap write and accept on the same IDLE edge: new tap applies
    do_reset();
    i_tap_addr = 2'd0;
    i_tap = 16'sh4000;
    i_tap_wr = 1'b1;
    taps_m[0] = 16384;
    send(2000, "same_edge", got);
    i_tap_wr = 1'b0;
    chk("same_edge_const", got, 1000);

    // Throughput with i_ce held high and incrementing samples
    do_reset();
    i_ce = 1'b1;
    last = -1; lowrun = 0; acc_n = 0;
    for (int c = 0; c < 60; c++) begin
      i_sample = 16'(100 + c);
      if (o_valid) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("thru_result", o_result, e);
        end else chk("thru_spurious_valid", 1, 0);
      end
      if (o_ready) begin
        if (acc_n > 0) begin
          chk("thru_gap", c - last, NT + 2);
          chk("thru_ready_low", lowrun, NT + 1);
        end
        last = c; lowrun = 0; acc_n++;
        m_accept(100 + c, r);
        q.push_back(r);
      end else lowrun++;
      tick();
    end
    i_ce = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (o_valid && q.size() > 0) begin
        e = q.pop_front();
        chk("thru_drain_result", o_result, e);
      end
      tick();
    end
    chk("thru_all_drained", q.size(), 0);

    // Tap write during MAC is ignored; reset mid-MAC aborts
    do_reset();
    i_sample = 16'sd500;
    i_ce = 1'b1;
    tick();
    i_ce = 1'b0;
    chk("abort_busy", longint'(o_busy), 1);
    chk("abort_notready", longint'(o_ready), 0);
    i_tap_addr = 2'd0;
    i_tap = '0;
    i_tap_wr = 1'b1;
    tick();
    i_tap_wr = 1'b0;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    m_reset();
    chk("abort_ready", longint'(o_ready), 1);
    chk("abort_busy_low", longint'(o_busy), 0);
    seen = o_valid;
    for (int c = 0; c < 8; c++) begin
      tick();
      seen = seen | o_valid;
    end
    chk("abort_no_valid", longint'(seen), 0);
    send(1000, "abort_after", got);
    chk("abort_after_const", got, 1000);

    // Random taps and samples against the model
    do_reset();
    for (int a = 0; a < NT; a++) wr_tap(a, longint'($urandom_range(0, 65535)) - 32768);
    for (int i = 0; i < 25; i++)
      send(longint'($urandom_range(0, 65535)) - 32768, $sformatf("rnd%0d", i), got);
    do_reset();
    for (int a = 0; a < NT; a++) wr_tap(a, longint'($urandom_range(0, 16383)) - 8192);
    for (int i = 0; i < 25; i++)
      send(longint'($urandom_range(0, 65535)) - 32768, $sformatf("rnds%0d", i), got);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/fir_filter_ctrl.md
Name: fir_filter_ctrl

Overview:
Parametrised successor to the fixed single-path filter controller. Accepts fixed-point audio samples over a valid/ready handshake and stores them in a circular delay line. Runs a time-multiplexed single-MAC FIR over a run-time-loadable tap bank, then rounds, shifts and saturates the result to the output width. Optional DC-removal prefilter is built in, so the float conversion stages are no longer needed in the mic-to-output path.

Parameters:
IW, 16, input sample width (signed)
CW, 16, tap coefficient width (signed)
OW, 16, output width (signed)
NTAPS, 16, number of taps / delay-line depth (>=2)
SHIFT, 15, right shift applied to accumulator before saturation (>=1)
DC_SHIFT, 6, DC tracker time constant (only with DC_REMOVE_EN)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_ce  in  1  sample valid
o_ready  out  1  block can accept a sample this cycle
i_sample  in  IW  input sample
i_tap_wr  in  1  tap write strobe (active high)
i_tap_addr  in  $clog2(NTAPS)  tap index to write
i_tap  in  CW  tap value
o_valid  out  1  one-cycle result strobe
o_result  out  OW  filtered output
o_busy  out  1  MAC in progress
i_ovf_clr  in  1  clears o_ovf
o_ovf  out  1  sticky saturation flag

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_reset: all state updates on the i_clk edge when i_reset=1.
- Reset values:
  - o_ready=1, o_valid=0, o_result=0, o_busy=0, o_ovf=0.
  - FSM=IDLE; write pointer=0; all delay-line entries=0.
  - tap[0]=2^(CW-1)-1, i.e. near-unity passthrough; all other taps=0.
- FSM states:
  - IDLE: o_ready=1. A sample is accepted on an edge where i_ce=1 and o_ready=1.
    - Sample is written to delay[wptr]; wptr advances mod NTAPS (wraps NTAPS-1 -> 0).
    - Accumulator is cleared; k=0; go to MAC.
  - MAC: lasts NTAPS cycles. o_busy=1, o_ready=0.
    - Each cycle: acc += tap[k] * delay[(newest - k) mod NTAPS]; k++.
    - Go to OUT after k=NTAPS-1.
  - OUT: lasts 1 cycle. o_valid=1 and o_result is updated; go to IDLE.
- Latency and throughput:
  - o_valid rises NTAPS+1 cycles after the accepting edge.
  - Maximum throughput is one sample per NTAPS+2 cycles.
  - i_ce while o_ready=0 is ignored; the sample is not queued.
- Arithmetic:
  - Accumulator width AW = IW+CW+$clog2(NTAPS), signed.
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT (round half up).
  - If r > 2^(OW-1)-1, or r < -2^(OW-1): clamp to that limit and set o_ovf.
  - o_result holds its value between o_valid pulses.
- Tap writes:
  - Honoured only in IDLE; tap[i_tap_addr] <= i_tap.
  - Ignored in MAC and OUT, with no error.
  - i_tap_wr and an accepted i_ce on the same IDLE edge: the write lands first, so the new tap is used for that sample.
- o_ovf: sticky.
  - i_ovf_clr clears it.
  - If a saturation and i_ovf_clr occur in the same cycle, the set wins.
- Reset during MAC or OUT aborts the computation: no o_valid is produced, and the delay line and taps return to their reset values.

Optional Feature:
FIR_DC_REMOVE_EN
- Defined:
  - The sample entering the delay line is d = x - avg, saturated to IW.
  - On each accept: avg <= avg + ((x - avg) >>> DC_SHIFT). avg is IW+DC_SHIFT bits wide, reset to 0; the integer part is compared against x.
  - Latency is unchanged.
- Undefined: x is stored unmodified and the avg register is absent.

Test Plan:
All scenarios use NTAPS=4, IW=CW=OW=16, SHIFT=15, feature off unless stated.
1. Reset, then one sample 1000 -> o_valid exactly 5 cycles after accept, o_result=1000; o_ovf=0.
2. Write taps 0..3 = 0x2000 in IDLE, feed 4000 four times -> o_result sequence 1000, 2000, 3000, 4000.
3. Taps all 0x7FFF, samples 32767 -> o_result=32767, o_ovf=1. Samples -32768 -> o_result=-32768. Pulse i_ovf_clr -> o_ovf=0.
4. i_ce held high with incrementing samples -> one accept per 6 cycles; o_ready low for 5 cycles after each accept; no sample accepted while o_ready=0.
5. Tap write to addr 0 with value 0 during MAC, then i_reset=1 on the 2nd MAC cycle -> no o_valid; next cycle o_ready=1. A following sample 1000 gives 1000, proving the write was ignored and the reset taps and zeroed delay line are in effect.
6. FIR_DC_REMOVE_EN on, DC_SHIFT=2, constant input 800 for 40 samples -> o_result decays monotonically from 800 toward |o_result| <= 4.
